// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory arbiter: FSM states, requester select
// and memory access size codes.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    IBUS = 1'b0,
    DBUS = 1'b1
  } arb_sel_t;

  localparam logic [2:0] MSIZE_B = 3'd0;
  localparam logic [2:0] MSIZE_H = 3'd1;
  localparam logic [2:0] MSIZE_W = 3'd2;
  localparam logic [2:0] MSIZE_D = 3'd3;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational grant selection between ibus and dbus.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise dbus always wins.
module mem_bus_arbiter_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic     i_valid,
  input  logic     d_valid,
`ifdef MEM_ARB_RR_EN
  input  arb_sel_t last_sel,
`endif
  output logic     grant,
  output arb_sel_t grant_sel
);

  always_comb begin
    grant     = i_valid | d_valid;
    grant_sel = d_valid ? DBUS : IBUS;
`ifdef MEM_ARB_RR_EN
    // On a collision hand the bus to whoever did not get it last time.
    if (i_valid && d_valid) begin
      grant_sel = (last_sel == DBUS) ? IBUS : DBUS;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch (ibus) and load/store (dbus).
// Optional round-robin collision handling is enabled by MEM_ARB_RR_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int IDATA_W = 32,
  parameter int DDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_data_ok,
  output logic [IDATA_W-1:0] i_data,
  input  logic               d_valid,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic               d_write,
  input  logic [2:0]         d_size,
  input  logic [7:0]         d_strobe,
  input  logic [DDATA_W-1:0] d_wdata,
  output logic               d_data_ok,
  output logic [DDATA_W-1:0] d_data,
  output logic               m_valid,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_write,
  output logic [2:0]         m_size,
  output logic [7:0]         m_strobe,
  output logic [DDATA_W-1:0] m_wdata,
  input  logic               m_ok,
  input  logic [DDATA_W-1:0] m_rdata,
  output arb_state_t         dbg_state
);

  // Handshake: a requester raises valid with stable fields and holds it until
  // its data_ok pulse; m_valid stays high with m_* frozen until m_ok.
  arb_state_t         state_q, state_d;
  logic               m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic               m_write_q, m_write_d;
  logic [2:0]         m_size_q, m_size_d;
  logic [7:0]         m_strobe_q, m_strobe_d;
  logic [DDATA_W-1:0] m_wdata_q, m_wdata_d;
  logic               grant;
  arb_sel_t           grant_sel;
`ifdef MEM_ARB_RR_EN
  arb_sel_t           last_q, last_d;
`endif

  mem_bus_arbiter_arb_pick u_pick (
    .i_valid   (i_valid),
    .d_valid   (d_valid),
`ifdef MEM_ARB_RR_EN
    .last_sel  (last_q),
`endif
    .grant     (grant),
    .grant_sel (grant_sel)
  );

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_write_d  = m_write_q;
    m_size_d   = m_size_q;
    m_strobe_d = m_strobe_q;
    m_wdata_d  = m_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          m_valid_d = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_d    = grant_sel;
`endif
          if (grant_sel == DBUS) begin
            state_d    = BUSY_D;
            m_addr_d   = d_addr;
            m_write_d  = d_write;
            m_size_d   = d_size;
            m_strobe_d = d_strobe;
            m_wdata_d  = d_wdata;
          end else begin
            state_d    = BUSY_I;
            m_addr_d   = i_addr;
            m_write_d  = 1'b0;
            m_size_d   = MSIZE_W;
            m_strobe_d = '0;
            m_wdata_d  = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ok) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_write_q  <= 1'b0;
      m_size_q   <= '0;
      m_strobe_q <= '0;
      m_wdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= IBUS;
`endif
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_write_q  <= m_write_d;
      m_size_q   <= m_size_d;
      m_strobe_q <= m_strobe_d;
      m_wdata_q  <= m_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // A requester that dropped valid mid-transaction gets its response discarded.
  assign i_data_ok = (state_q == BUSY_I) & m_ok & i_valid;
  assign d_data_ok = (state_q == BUSY_D) & m_ok & d_valid;
  assign i_data    = m_addr_q[2] ? m_rdata[2*IDATA_W-1:IDATA_W] : m_rdata[IDATA_W-1:0];
  assign d_data    = m_rdata;

  assign m_valid   = m_valid_q;
  assign m_addr    = m_addr_q;
  assign m_write   = m_write_q;
  assign m_size    = m_size_q;
  assign m_strobe  = m_strobe_q;
  assign m_wdata   = m_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (MEM_ARB_RR_EN selects the round-robin model).
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int REQ_W = 1 + 64 + 1 + 3 + 8 + 64;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, d_valid, d_write, m_ok;
  logic [63:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic        i_data_ok, d_data_ok, m_valid, m_write;
  logic [31:0] i_data;
  logic [63:0] d_data, m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  arb_state_t  dbg_state;

  // Outstanding memory transaction (at most one): {who, addr, write, size, strobe, wdata}
  logic [REQ_W-1:0] exp_q[$];
  bit               mdl_last;
  bit               last_iok, last_dok;
  int               mem_wait;
  int               n_total = 0;
  int               n_bad   = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_strobe(d_strobe), .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_size(m_size),
    .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ok(m_ok), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Compare DUT outputs at the negative edge, then advance the model to the next posedge.
  task automatic sample();
    logic        r_who, r_write, exp_mv, exp_iok, exp_dok;
    logic [63:0] r_addr, r_wdata;
    logic [2:0]  r_size;
    logic [7:0]  r_strobe;
    arb_state_t  exp_st;
    @(negedge clk);
    {r_who, r_addr, r_write, r_size, r_strobe, r_wdata} = (exp_q.size() != 0) ? exp_q[0] : '0;
    exp_mv  = !rst && (exp_q.size() != 0);
    exp_iok = exp_mv && !r_who && m_ok && i_valid;
    exp_dok = exp_mv && r_who && m_ok && d_valid;
    exp_st  = !exp_mv ? IDLE : (r_who ? BUSY_D : BUSY_I);
    check("m_valid", m_valid, exp_mv);
    check("state", 64'(dbg_state), 64'(exp_st));
    check("i_data_ok", i_data_ok, exp_iok);
    check("d_data_ok", d_data_ok, exp_dok);
    if (exp_mv) begin
      check("m_addr", m_addr, r_addr);
      check("m_write", m_write, r_write);
      check("m_size", 64'(m_size), 64'(r_size));
      check("m_strobe", 64'(m_strobe), 64'(r_strobe));
      check("m_wdata", m_wdata, r_wdata);
    end
    if (exp_iok) check("i_data", i_data, r_addr[2] ? m_rdata[63:32] : m_rdata[31:0]);
    if (exp_dok) check("d_data", d_data, m_rdata);
    last_iok = exp_iok;
    last_dok = exp_dok;
    // Model step: what the arbiter must do at the coming edge.
    if (rst) begin
      exp_q.delete();
      mdl_last = 1'b0;
    end else if (exp_q.size() == 0) begin
      if (i_valid || d_valid) begin
        bit pick_d;
        pick_d = (i_valid && d_valid) ? (RR_EN ? !mdl_last : 1'b1) : d_valid;
        if (pick_d) exp_q.push_back({1'b1, d_addr, d_write, d_size, d_strobe, d_wdata});
        else        exp_q.push_back({1'b0, i_addr, 1'b0, MSIZE_W, 8'h00, 64'h0});
        mdl_last = pick_d;
        mem_wait = $urandom_range(0, 4);
      end
    end else if (m_ok) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drive_random();
    if (last_iok) begin
      i_valid = 1'($urandom_range(0, 1));
      i_addr  = rnd64();
    end else if (!i_valid) begin
      if ($urandom_range(0, 2) == 0) begin
        i_valid = 1'b1;
        i_addr  = rnd64();
      end
    end else if ($urandom_range(0, 15) == 0) begin
      i_valid = 1'b0;
    end
    if (last_dok || (!d_valid && $urandom_range(0, 2) == 0)) begin
      d_valid  = last_dok ? 1'($urandom_range(0, 1)) : 1'b1;
      d_addr   = rnd64();
      d_write  = 1'($urandom_range(0, 1));
      d_size   = 3'($urandom_range(0, 3));
      d_strobe = 8'($urandom_range(0, 255));
      d_wdata  = rnd64();
    end else if (d_valid && $urandom_range(0, 15) == 0) begin
      d_valid = 1'b0;
    end else if (d_valid && $urandom_range(0, 15) == 0) begin
      d_addr = rnd64();
    end
    if (exp_q.size() != 0) begin
      if (mem_wait == 0) m_ok = 1'b1;
      else begin
        m_ok = 1'b0;
        mem_wait--;
      end
    end else begin
      m_ok = ($urandom_range(0, 15) == 0);
    end
    m_rdata = rnd64();
  endtask

  initial begin
    rst = 1'b1;
    {i_valid, d_valid, d_write, m_ok} = '0;
    {i_addr, d_addr, d_wdata, m_rdata} = '0;
    d_size = '0; d_strobe = '0;
    mdl_last = 1'b0; mem_wait = 0; last_iok = 0; last_dok = 0;
    advance();
    advance();
    sample();
    check("rst_m_addr", m_addr, 64'h0);
    check("rst_m_write", m_write, 64'h0);
    check("rst_m_size", 64'(m_size), 64'h0);
    check("rst_m_strobe", 64'(m_strobe), 64'h0);
    check("rst_m_wdata", m_wdata, 64'h0);
    advance();
    rst = 1'b0;

    // Single fetch with memory answering three cycles after m_valid.
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    cyc();
    check("fetch_m_valid", m_valid, 64'h1);
    cyc(); cyc(); cyc();
    m_ok = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
    sample();
    check("fetch_m_addr", m_addr, 64'h8000_0004);
    check("fetch_m_write", m_write, 64'h0);
    check("fetch_iok", i_data_ok, 64'h1);
    check("fetch_idata", i_data, 64'h1111_2222);
    advance();
    i_valid = 1'b0; m_ok = 1'b0;
    cyc();

    // Collision: dbus store and ibus fetch raised together; then address changed mid-flight.
    i_valid = 1'b1; i_addr = 64'h40;
    d_valid = 1'b1; d_addr = 64'h100; d_write = 1'b1; d_wdata = 64'hDEAD;
    d_size = MSIZE_D; d_strobe = 8'hFF;
    cyc();
    check("coll_m_write", m_write, 64'h1);
    check("coll_m_wdata", m_wdata, 64'hDEAD);
    d_addr = 64'h200;
    cyc(); cyc();
    check("stable_m_addr", m_addr, 64'h100);
    m_ok = 1'b1; m_rdata = rnd64();
    sample();
    check("coll_dok", d_data_ok, 64'h1);
    advance();
    d_valid = 1'b0; m_ok = 1'b0;
    cyc();
    check("coll_i_after", m_addr, 64'h40);
    m_ok = 1'b1;
    cyc();
    i_valid = 1'b0; m_ok = 1'b0;
    cyc();

    // Collision right after a dbus grant: round-robin favours ibus, fixed priority dbus.
    d_valid = 1'b1; d_addr = 64'h500; d_write = 1'b1; d_wdata = 64'hBEEF;
    cyc();
    m_ok = 1'b1;
    cyc();
    m_ok = 1'b0; d_addr = 64'h600; i_valid = 1'b1; i_addr = 64'h700;
    cyc();
    check("rr_pick_write", m_write, RR_EN ? 64'h0 : 64'h1);
    check("rr_pick_addr", m_addr, RR_EN ? 64'h700 : 64'h600);
    m_ok = 1'b1;
    cyc();
    if (RR_EN) i_valid = 1'b0;
    else       d_valid = 1'b0;
    m_ok = 1'b0;
    cyc();
    m_ok = 1'b1;
    cyc();
    i_valid = 1'b0; d_valid = 1'b0; m_ok = 1'b0;
    cyc();

    // Flush: fetch dropped after grant; its response is discarded.
    i_valid = 1'b1; i_addr = 64'h80;
    cyc();
    i_valid = 1'b0;
    cyc();
    m_ok = 1'b1; m_rdata = rnd64();
    sample();
    check("flush_iok", i_data_ok, 64'h0);
    advance();
    m_ok = 1'b0;
    d_valid = 1'b1; d_addr = 64'h400; d_write = 1'b0;
    cyc();
    check("flush_next_mv", m_valid, 64'h1);
    check("flush_next_addr", m_addr, 64'h400);
    m_ok = 1'b1;
    cyc();
    d_valid = 1'b0; m_ok = 1'b0;
    cyc();

    // Reset in the middle of a dbus transaction.
    d_valid = 1'b1; d_addr = 64'h300;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("rst_async_mv", m_valid, 64'h0);
    sample();
    advance();
    rst = 1'b0; d_valid = 1'b0; m_ok = 1'b1;
    sample();
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_dok", d_data_ok, 64'h0);
    advance();
    m_ok = 1'b0;

    // Fetch stream with a pending dbus request: dbus takes the next idle slot.
    i_valid = 1'b1; i_addr = 64'h1000;
    cyc();
    d_valid = 1'b1; d_write = 1'b0; d_addr = 64'h2000; m_ok = 1'b1;
    cyc();
    i_addr = 64'h1004; m_ok = 1'b0;
    cyc();
    check("stream_d_wins", m_addr, 64'h2000);
    m_ok = 1'b1;
    cyc();
    d_valid = 1'b0; m_ok = 1'b0;
    cyc();
    check("stream_i_next", m_addr, 64'h1004);
    m_ok = 1'b1;
    cyc();
    i_valid = 1'b0; m_ok = 1'b0;
    cyc();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
